// File: rtl/trig_stretch_count_if.sv
// Bus bundle for trig_stretch_count: raw/stretched triggers, scaler control and readout.
// The master drives triggers and readout address; the slave (the block) returns pulses and counts.
interface trig_stretch_count_if #(
    parameter int NBEAMS      = 54,
    parameter int NLEVEL      = 2,
    parameter int CNT_BITS    = 16,
    parameter int PERIOD_BITS = 24
);
    localparam int NCH = NLEVEL * NBEAMS;
    localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NLEVEL-1:0][NBEAMS-1:0] trig_i;
    logic                          enable_i;
    logic [PERIOD_BITS-1:0]        period_i;
    logic [NLEVEL-1:0][NBEAMS-1:0] trig_o;
    logic                          done_o;
    logic                          bank_o;
    logic [AW-1:0]                 rd_adr_i;
    logic [CNT_BITS-1:0]           rd_dat_o;

    modport master (
        output trig_i, enable_i, period_i, rd_adr_i,
        input  trig_o, done_o, bank_o, rd_dat_o
    );

    modport slave (
        input  trig_i, enable_i, period_i, rd_adr_i,
        output trig_o, done_o, bank_o, rd_dat_o
    );
endinterface

// File: rtl/trig_stretch_count.sv
// Per-channel trigger stretcher with holdoff, plus saturating per-channel scalers that are
// latched into a readable holding bank at the end of every measurement period.
module trig_stretch_count #(
    parameter int NBEAMS      = 54,
    parameter int NLEVEL      = 2,
    parameter int STRETCH     = 4,
    parameter int HOLDOFF     = 0,
    parameter int CNT_BITS    = 16,
    parameter int PERIOD_BITS = 24
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    trig_stretch_count_if.slave bus
);
    localparam int NCH = NLEVEL * NBEAMS;
    localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STRETCH, S_HOLD} state_t;

    state_t              r_state [NCH];
    logic [7:0]          r_cnt   [NCH];
    logic [NCH-1:0]      r_trig;
    logic [CNT_BITS-1:0] r_acc   [NCH];
    logic [CNT_BITS-1:0] r_hold  [NCH];
    logic [PERIOD_BITS-1:0] r_timer;
    logic                r_done;
    logic                r_bank;
    logic [CNT_BITS-1:0] r_rd_dat;

    logic [NCH-1:0]      w_trig_in;
    logic [NCH-1:0]      w_accept;
    logic                w_boundary;
    logic                w_adr_ok;

    // Flat channel index is level*NBEAMS+beam, matching the packed layout of trig_i.
    assign w_trig_in = bus.trig_i;

    always_comb begin
        w_accept = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_accept[ch] = (r_state[ch] == S_IDLE) && w_trig_in[ch];
        end
    end

    assign w_boundary = bus.enable_i && (bus.period_i != '0) &&
                        (r_timer >= bus.period_i - PERIOD_BITS'(1));

    // NOTE: every register below uses non-blocking assignment so all channels update from the same pre-edge state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_trig <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_state[ch] <= S_IDLE;
                r_cnt[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                case (r_state[ch])
                    S_IDLE: begin
                        if (w_trig_in[ch]) begin
                            r_state[ch] <= S_STRETCH;
                            r_cnt[ch]   <= 8'(STRETCH - 1);
                            r_trig[ch]  <= 1'b1;
                        end
                    end
                    S_STRETCH: begin
                        if (r_cnt[ch] == '0) begin
                            r_trig[ch] <= 1'b0;
                            if (HOLDOFF > 0) begin
                                r_state[ch] <= S_HOLD;
                                r_cnt[ch]   <= 8'(HOLDOFF - 1);
                            end else begin
                                r_state[ch] <= S_IDLE;
                            end
                        end else begin
                            r_cnt[ch] <= r_cnt[ch] - 8'd1;
                        end
                    end
                    S_HOLD: begin
                        if (r_cnt[ch] == '0) r_state[ch] <= S_IDLE;
                        else                 r_cnt[ch]   <= r_cnt[ch] - 8'd1;
                    end
                    default: begin
                        r_state[ch] <= S_IDLE;
                        r_trig[ch]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_timer <= '0;
            r_done  <= 1'b0;
            r_bank  <= 1'b0;
        end else begin
            r_done <= w_boundary;
            if (w_boundary) r_bank <= ~r_bank;
            if (!bus.enable_i || (bus.period_i == '0) || w_boundary) r_timer <= '0;
            else                                                    r_timer <= r_timer + PERIOD_BITS'(1);
        end
    end

    // NOTE: the holding bank is reset (not left uninitialised) because readout must return 0 after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_acc[ch]  <= '0;
                r_hold[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (!bus.enable_i) begin
                    r_acc[ch] <= '0;
                end else if (w_boundary) begin
                    r_hold[ch] <= r_acc[ch];
                    r_acc[ch]  <= CNT_BITS'(w_accept[ch]);
                end else if (w_accept[ch] && (r_acc[ch] != '1)) begin
                    r_acc[ch] <= r_acc[ch] + CNT_BITS'(1);
                end
            end
        end
    end

    // Extra top bit keeps the range check correct even when NCH is a power of two.
    assign w_adr_ok = {1'b0, bus.rd_adr_i} < (AW + 1)'(NCH);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      r_rd_dat <= '0;
        else if (w_adr_ok) r_rd_dat <= r_hold[bus.rd_adr_i];
        else               r_rd_dat <= '0;
    end

    assign bus.trig_o   = r_trig;
    assign bus.done_o   = r_done;
    assign bus.bank_o   = r_bank;
    assign bus.rd_dat_o = r_rd_dat;
endmodule
